// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT scheduler and its call interface.
package tft_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_IDLE  = 3'd3,
    ST_DRAW  = 3'd4,
    ST_ACK   = 3'd5
  } state_e;

  localparam int CALL_PIXEL = 2;
  localparam int CALL_CLEAR = 1;
  localparam int CALL_INIT  = 0;

  localparam int PIX_X_MSB     = 31;
  localparam int PIX_X_LSB     = 24;
  localparam int PIX_Y_MSB     = 23;
  localparam int PIX_Y_LSB     = 16;
  localparam int PIX_COLOR_MSB = 15;
  localparam int PIX_COLOR_LSB = 0;

  function automatic logic [2:0] call_bit(input int idx);
    logic [2:0] v;
    v = 3'b000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tft_rr_arb.sv
// Two-way round-robin grant; the last-served pointer register lives in the parent.
module tft_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/tft_schedmod.sv
// Power-up sequencer and pixel-call arbiter feeding tft_ctrlmod's iCall/iData.
module tft_schedmod
  import tft_pkg::*;
#(
  parameter int T_PWRUP    = 50000,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [1:0]  iReq,
  input  logic [31:0] iData0,
  input  logic [31:0] iData1,
  input  logic        iClear,
  output logic [1:0]  oAck,
  output logic        oReady,
  output logic        oBusy,
  output logic [2:0]  oCall,
  input  logic        iDone,
  output logic [31:0] oData
);

  localparam logic [16:0] PWR_LAST = (T_PWRUP > 0) ? 17'(T_PWRUP - 1) : 17'd0;

  state_e      state_q;
  logic [16:0] cnt_q;
  logic        pend_q;
  logic        last_q;
  logic        gnt_q;
  logic [2:0]  call_q;
  logic [1:0]  ack_q;
  logic        ready_q;
  logic        busy_q;
  logic [31:0] data_q;
  logic [1:0]  grant;

  tft_rr_arb u_arb (
    .req_i   (iReq),
    .last_i  (last_q),
    .grant_o (grant)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      // Pointer holds the last-served index; 1 makes requester 0 win the first tie.
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      call_q  <= 3'b000;
      ack_q   <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      // A clear arriving on the clear-done edge wins, so the request is not lost.
      if (iClear && state_q != ST_WAIT)
        pend_q <= 1'b1;
      else if (state_q == ST_CLEAR && iDone)
        pend_q <= 1'b0;

      ack_q <= 2'b00;

      case (state_q)
        ST_WAIT: begin
          if (cnt_q >= PWR_LAST) begin
            state_q <= ST_INIT;
            call_q  <= call_bit(CALL_INIT);
          end else begin
            cnt_q <= cnt_q + 17'd1;
          end
        end
        ST_INIT: begin
          if (iDone) begin
            call_q <= 3'b000;
            if (INIT_CLEAR) begin
              state_q <= ST_CLEAR;
            end else begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            call_q <= call_bit(CALL_INIT);
          end
        end
        ST_CLEAR: begin
          if (iDone) begin
            call_q  <= 3'b000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            call_q <= call_bit(CALL_CLEAR);
          end
        end
        ST_IDLE: begin
          if (pend_q) begin
            state_q <= ST_CLEAR;
            call_q  <= call_bit(CALL_CLEAR);
            busy_q  <= 1'b1;
          end else if (grant != 2'b00) begin
            data_q  <= grant[1] ? iData1 : iData0;
            gnt_q   <= grant[1];
            call_q  <= call_bit(CALL_PIXEL);
            busy_q  <= 1'b1;
            state_q <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (iDone) begin
            call_q  <= 3'b000;
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            last_q  <= gnt_q;
            state_q <= ST_ACK;
          end else begin
            call_q <= call_bit(CALL_PIXEL);
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_WAIT;
          call_q  <= 3'b000;
        end
      endcase
    end
  end

  assign oAck   = ack_q;
  assign oReady = ready_q;
  assign oBusy  = busy_q;
  assign oCall  = call_q;
  assign oData  = data_q;

endmodule

// File: tb/tb_tft_schedmod.sv
// Bench for tft_schedmod: a tft_ctrlmod stand-in answers each call after 5 cycles.
module tb_tft_schedmod;

  localparam int T_PW = 10;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  iReq = 2'b00;
  logic [31:0] iData0 = '0;
  logic [31:0] iData1 = '0;
  logic        iClear = 1'b0;
  logic        iDone = 1'b0;
  logic [1:0]  oAck;
  logic        oReady;
  logic        oBusy;
  logic [2:0]  oCall;
  logic [31:0] oData;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  tft_schedmod #(.T_PWRUP(T_PW), .INIT_CLEAR(1'b1)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .iReq   (iReq),
    .iData0 (iData0),
    .iData1 (iData1),
    .iClear (iClear),
    .oAck   (oAck),
    .oReady (oReady),
    .oBusy  (oBusy),
    .oCall  (oCall),
    .iDone  (iDone),
    .oData  (oData)
  );

  always #5 CLOCK = ~CLOCK;

  // Controller stand-in: pulses iDone on the 5th cycle a call is held.
  int done_cnt = 0;
  always @(negedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      iDone = 1'b0;
      done_cnt = 0;
    end else if (iDone) begin
      iDone = 1'b0;
    end else if (oCall != 3'b000) begin
      done_cnt++;
      if (done_cnt == 5) begin
        iDone = 1'b1;
        done_cnt = 0;
      end
    end else begin
      done_cnt = 0;
    end
  end

  // Scoreboard consumer and one-hot monitor.
  always begin
    @(posedge CLOCK);
    #1;
    if (RESET) begin
      n_checks++;
      if (!$onehot0(oCall) || !$onehot0(oAck)) begin
        n_fail++;
        $display("FAIL onehot: oCall=%b oAck=%b required at most one bit each", oCall, oAck);
      end
      if (oAck != 2'b00) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_ack: oAck=%b oData=%h with nothing expected", oAck, oData);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (oAck !== e.ack || oData !== e.data) begin
            n_fail++;
            $display("FAIL sb_txn: oAck=%b oData=%h required oAck=%b oData=%h", oAck, oData, e.ack, e.data);
          end else begin
            $display("txn ack=%b data=%h ok", oAck, oData);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] ack, input logic [31:0] data);
    exp_t e;
    e.ack = ack;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_call(input logic [2:0] want, input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(posedge CLOCK);
      #1;
      cycles++;
      if (oCall === want) ok = 1'b1;
    end
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge CLOCK);
      #1;
      if (oReady === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge CLOCK);
      #1;
      if (oAck !== 2'b00) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    bit ok;
    RESET = 1'b0;
    iReq = 2'b00;
    iClear = 1'b0;
    #12;
    @(negedge CLOCK);
    RESET = 1'b1;
    wait_ready(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reinit_ready: oReady=%b required 1", oReady); end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #12;
    n_checks++;
    if (oCall !== 3'b000 || oAck !== 2'b00 || oReady !== 1'b0 || oData !== 32'h0 || oBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: oCall=%b oAck=%b oReady=%b oData=%h oBusy=%b required 000 00 0 0 1",
               oCall, oAck, oReady, oData, oBusy);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  task automatic test_powerup();
    bit ok;
    int cyc;
    logic [2:0] want;
    for (int k = 1; k <= T_PW; k++) begin
      @(posedge CLOCK);
      #1;
      want = (k == T_PW) ? 3'b001 : 3'b000;
      n_checks++;
      if (oCall !== want) begin
        n_fail++;
        $display("FAIL pwrup_call cycle %0d: oCall=%b required %b", k, oCall, want);
      end
    end
    wait_call(3'b010, 20, ok, cyc);
    n_checks++;
    if (!ok || oReady !== 1'b0) begin
      n_fail++;
      $display("FAIL pwrup_clear: oCall=%b oReady=%b required 010 0", oCall, oReady);
    end
    wait_ready(20, ok);
    n_checks++;
    if (!ok || oCall !== 3'b000 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL pwrup_ready: oReady=%b oCall=%b oBusy=%b required 1 000 0", oReady, oCall, oBusy);
    end
    $display("powerup sequence done");
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    @(posedge CLOCK);
    #1;
    iData0 = 32'h1020F800;
    iReq = 2'b01;
    push_exp(2'b01, 32'h1020F800);
    wait_call(3'b100, 10, ok, cyc);
    n_checks++;
    if (!ok || cyc != 1 || oData !== 32'h1020F800) begin
      n_fail++;
      $display("FAIL single_call: ok=%0d edges=%0d oData=%h required 1 1 1020f800", ok, cyc, oData);
    end
    wait_ack(20, ok);
    n_checks++;
    if (!ok || oAck !== 2'b01 || iDone !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: oAck=%b iDone=%b required 01 1", oAck, iDone);
    end
    iReq = 2'b00;
    @(posedge CLOCK);
    #1;
    n_checks++;
    if (oAck !== 2'b00 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: oAck=%b oBusy=%b required 00 0", oAck, oBusy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int acks = 0;
    int sent0 = 1;
    int sent1 = 1;
    do_reset();
    @(posedge CLOCK);
    #1;
    iData0 = 32'hA0A1F000;
    iData1 = 32'hB0B10F0F;
    push_exp(2'b01, 32'hA0A1F000);
    push_exp(2'b10, 32'hB0B10F0F);
    iReq = 2'b11;
    for (int i = 0; i < 200 && acks < 4; i++) begin
      @(posedge CLOCK);
      #1;
      if (oAck == 2'b01) begin
        acks++;
        if (sent0 < 2) begin iData0 = 32'hA2A30001; push_exp(2'b01, 32'hA2A30001); sent0++; end
        else iReq[0] = 1'b0;
      end else if (oAck == 2'b10) begin
        acks++;
        if (sent1 < 2) begin iData1 = 32'hB2B37777; push_exp(2'b10, 32'hB2B37777); sent1++; end
        else iReq[1] = 1'b0;
      end
    end
    iReq = 2'b00;
    n_checks++;
    if (acks != 4) begin
      n_fail++;
      $display("FAIL rr_count: acks=%0d required 4", acks);
    end
  endtask

  task automatic test_clear_priority();
    bit ok;
    int cyc;
    @(posedge CLOCK);
    #1;
    iData1 = 32'h05060123;
    iReq = 2'b10;
    push_exp(2'b10, 32'h05060123);
    wait_call(3'b100, 10, ok, cyc);
    iData0 = 32'h0708ABCD;
    iReq = 2'b11;
    iClear = 1'b1;
    push_exp(2'b01, 32'h0708ABCD);
    @(posedge CLOCK);
    #1;
    iClear = 1'b0;
    wait_ack(20, ok);
    n_checks++;
    if (!ok || oAck !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_first_ack: oAck=%b required 10", oAck);
    end
    iReq[1] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge CLOCK);
      #1;
      if (oCall !== 3'b000) ok = 1'b1;
    end
    n_checks++;
    if (!ok || oCall !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_clear_first: oCall=%b required 010", oCall);
    end
    wait_ack(40, ok);
    n_checks++;
    if (!ok || oAck !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_second_ack: oAck=%b required 01", oAck);
    end
    iReq = 2'b00;
  endtask

  task automatic test_clear_on_done();
    bit ok;
    int cyc;
    @(posedge CLOCK);
    #1;
    iClear = 1'b1;
    @(posedge CLOCK);
    #1;
    iClear = 1'b0;
    wait_call(3'b010, 5, ok, cyc);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cod_clear_start: oCall=%b required 010", oCall); end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLOCK);
      #1;
      if (iDone) ok = 1'b1;
    end
    iClear = 1'b1;
    @(posedge CLOCK);
    #1;
    iClear = 1'b0;
    n_checks++;
    if (!ok || oCall !== 3'b000) begin
      n_fail++;
      $display("FAIL cod_done_edge: oCall=%b required 000", oCall);
    end
    @(posedge CLOCK);
    #1;
    n_checks++;
    if (oCall !== 3'b010) begin
      n_fail++;
      $display("FAIL cod_second_clear: oCall=%b required 010", oCall);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge CLOCK);
      #1;
      if (oBusy === 1'b0) ok = 1'b1;
    end
    repeat (3) @(posedge CLOCK);
    #1;
    n_checks++;
    if (!ok || oCall !== 3'b000 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL cod_settle: oCall=%b oBusy=%b required 000 0", oCall, oBusy);
    end
  endtask

  task automatic test_reset_mid_draw();
    bit ok;
    int cyc;
    @(posedge CLOCK);
    #1;
    iData0 = 32'h11223344;
    iReq = 2'b01;
    wait_call(3'b100, 10, ok, cyc);
    #3;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (!ok || oCall !== 3'b000 || oAck !== 2'b00 || oReady !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: oCall=%b oAck=%b oReady=%b required 000 00 0", oCall, oAck, oReady);
    end
    iReq = 2'b00;
    @(negedge CLOCK);
    RESET = 1'b1;
    wait_call(3'b001, 20, ok, cyc);
    n_checks++;
    if (!ok || cyc != T_PW) begin
      n_fail++;
      $display("FAIL rst_reinit: edges=%0d required %0d", cyc, T_PW);
    end
    wait_call(3'b010, 20, ok, cyc);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_reclear: oCall=%b required 010", oCall); end
    wait_ready(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_ready: oReady=%b required 1", oReady); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_single();
    test_round_robin();
    test_clear_priority();
    test_clear_on_done();
    test_reset_mid_draw();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
